// File: rtl/div.sv
// div: multi-cycle radix-2 restoring 32-bit divider for the OpenMIPS EX stage.
// Serves DIV/DIVU and returns {remainder, quotient}, one quotient bit per clock.
module div (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_signed_div,
    input  logic [31:0] i_opdata1,
    input  logic [31:0] i_opdata2,
    input  logic        i_start,
    input  logic        i_annul,
    output logic [63:0] o_result,
    output logic        o_ready
);
    typedef enum logic [1:0] {FREE, BYZERO, ON, END} state_t;
    state_t      state, state_n;
    logic [64:0] work, work_n;
    logic [31:0] divisor, divisor_n;
    logic [5:0]  cnt, cnt_n;
    logic        neg_q, neg_q_n, neg_r, neg_r_n;
    logic [63:0] result_n;
    logic        ready_n;
    logic        a_neg, b_neg;
    logic [31:0] a_mag, b_mag, q, r;
    logic [32:0] d;
    always_comb begin
        a_neg     = i_signed_div & i_opdata1[31];
        b_neg     = i_signed_div & i_opdata2[31];
        a_mag     = a_neg ? -i_opdata1 : i_opdata1;
        b_mag     = b_neg ? -i_opdata2 : i_opdata2;
        d         = {1'b0, work[63:32]} - {1'b0, divisor};
        // remainder takes the dividend's sign, quotient is negative when signs differ
        q         = neg_q ? -work[31:0] : work[31:0];
        r         = neg_r ? -work[64:33] : work[64:33];
        state_n   = state;
        work_n    = work;
        divisor_n = divisor;
        cnt_n     = cnt;
        neg_q_n   = neg_q;
        neg_r_n   = neg_r;
        result_n  = o_result;
        ready_n   = o_ready;
        case (state)
            FREE: if (i_start && !i_annul) begin
                divisor_n = b_mag;
                work_n    = {32'b0, a_mag, 1'b0};
                neg_q_n   = a_neg ^ b_neg;
                neg_r_n   = a_neg;
                cnt_n     = 6'd0;
                state_n   = (i_opdata2 == 32'd0) ? BYZERO : ON;
            end
            BYZERO: begin
                state_n  = END;
                result_n = 64'd0;
                ready_n  = 1'b1;
            end
            ON: if (i_annul) begin
                state_n = FREE;
            end else if (cnt != 6'd32) begin
                work_n = d[32] ? {work[63:0], 1'b0} : {d[31:0], work[31:0], 1'b1};
                cnt_n  = cnt + 6'd1;
            end else begin
                state_n  = END;
                result_n = {r, q};
                ready_n  = 1'b1;
            end
            END: if (i_annul || !i_start) begin
                state_n  = FREE;
                result_n = 64'd0;
                ready_n  = 1'b0;
            end
            default: state_n = FREE;
        endcase
    end
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state    <= FREE;
            work     <= 65'd0;
            divisor  <= 32'd0;
            cnt      <= 6'd0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            o_result <= 64'd0;
            o_ready  <= 1'b0;
        end else begin
            state    <= state_n;
            work     <= work_n;
            divisor  <= divisor_n;
            cnt      <= cnt_n;
            neg_q    <= neg_q_n;
            neg_r    <= neg_r_n;
            o_result <= result_n;
            o_ready  <= ready_n;
        end
    end
endmodule

// File: tb/tb_div.sv
// tb_div: directed self-checking bench for the div block.
module tb_div;
    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        i_signed_div = 1'b0;
    logic [31:0] i_opdata1 = 32'd0;
    logic [31:0] i_opdata2 = 32'd0;
    logic        i_start = 1'b0;
    logic        i_annul = 1'b0;
    logic [63:0] o_result;
    logic        o_ready;
    int          total = 0;
    int          bad = 0;

    div dut (
        .i_clk(i_clk),
        .i_rst_n(i_rst_n),
        .i_signed_div(i_signed_div),
        .i_opdata1(i_opdata1),
        .i_opdata2(i_opdata2),
        .i_start(i_start),
        .i_annul(i_annul),
        .o_result(o_result),
        .o_ready(o_ready)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // counts edges after acceptance until o_ready, bounded at 40
    task automatic wait_ready(input string tag, input int want);
        int n = 0;
        do begin
            @(posedge i_clk); #1;
            n++;
        end while (!o_ready && n < 40);
        chk({tag, "-lat"}, 64'(n), 64'(want));
    endtask

    task automatic run(input string tag, input logic s, input logic [31:0] a,
                       input logic [31:0] b, input logic [63:0] exp);
        @(negedge i_clk);
        i_signed_div = s;
        i_opdata1 = a;
        i_opdata2 = b;
        i_start = 1'b1;
        @(posedge i_clk); #1;
        // operands and mode are don't-care after the latch edge
        i_signed_div = ~s;
        i_opdata1 = ~a;
        i_opdata2 = b + 32'd3;
        wait_ready(tag, (b == 32'd0) ? 1 : 33);
        chk({tag, "-res"}, o_result, exp);
        @(posedge i_clk); #1;
        chk({tag, "-hold_rdy"}, 64'(o_ready), 64'd1);
        chk({tag, "-hold_res"}, o_result, exp);
        @(negedge i_clk);
        i_start = 1'b0;
        @(posedge i_clk); #1;
        chk({tag, "-clr_rdy"}, 64'(o_ready), 64'd0);
        chk({tag, "-clr_res"}, o_result, 64'd0);
    endtask

    initial begin
        logic seen;
        repeat (2) @(posedge i_clk);
        #1;
        chk("rst_rdy", 64'(o_ready), 64'd0);
        chk("rst_res", o_result, 64'd0);
        i_rst_n = 1'b1;

        run("u100_7", 1'b0, 32'd100, 32'd7, 64'h00000002_0000000E);
        run("s-7_2", 1'b1, 32'hFFFFFFF9, 32'd2, 64'hFFFFFFFF_FFFFFFFD);
        run("s7_-2", 1'b1, 32'd7, 32'hFFFFFFFE, 64'h00000001_FFFFFFFD);
        run("s_min_-1", 1'b1, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000);
        run("u_min_max", 1'b0, 32'h80000000, 32'hFFFFFFFF, 64'h80000000_00000000);
        run("u_max_1", 1'b0, 32'hFFFFFFFF, 32'd1, 64'h00000000_FFFFFFFF);
        run("s_max_1", 1'b1, 32'hFFFFFFFF, 32'd1, 64'h00000000_FFFFFFFF);
        run("u_dead_16", 1'b0, 32'hDEADBEEF, 32'h10, 64'h0000000F_0DEADBEE);
        run("s-100_7", 1'b1, 32'hFFFFFF9C, 32'd7, 64'hFFFFFFFE_FFFFFFF2);
        run("u_div0", 1'b0, 32'h12345678, 32'd0, 64'd0);
        run("s_div0", 1'b1, 32'h80000000, 32'd0, 64'd0);

        // flush at E10 of an active division
        @(negedge i_clk);
        i_signed_div = 1'b0;
        i_opdata1 = 32'd1000;
        i_opdata2 = 32'd3;
        i_start = 1'b1;
        @(posedge i_clk);
        repeat (9) @(posedge i_clk);
        @(negedge i_clk);
        i_annul = 1'b1;
        @(posedge i_clk); #1;
        i_annul = 1'b0;
        i_start = 1'b0;
        seen = 1'b0;
        repeat (40) begin
            @(posedge i_clk); #1;
            seen |= o_ready;
        end
        chk("annul_no_rdy", 64'(seen), 64'd0);
        run("u9_3", 1'b0, 32'd9, 32'd3, 64'h00000000_00000003);

        // annul and start together in FREE: request ignored
        @(negedge i_clk);
        i_opdata1 = 32'd50;
        i_opdata2 = 32'd5;
        i_start = 1'b1;
        i_annul = 1'b1;
        seen = 1'b0;
        repeat (40) begin
            @(posedge i_clk); #1;
            seen |= o_ready;
        end
        i_annul = 1'b0;
        i_start = 1'b0;
        chk("annul_start_no_rdy", 64'(seen), 64'd0);
        run("u50_5", 1'b0, 32'd50, 32'd5, 64'h00000000_0000000A);

        // reset in the middle of a division at E20
        @(negedge i_clk);
        i_opdata1 = 32'd77;
        i_opdata2 = 32'd4;
        i_start = 1'b1;
        @(posedge i_clk);
        repeat (19) @(posedge i_clk);
        @(negedge i_clk);
        i_rst_n = 1'b0;
        @(posedge i_clk); #1;
        i_rst_n = 1'b1;
        i_start = 1'b0;
        chk("midrst_rdy", 64'(o_ready), 64'd0);
        chk("midrst_res", o_result, 64'd0);
        seen = 1'b0;
        repeat (40) begin
            @(posedge i_clk); #1;
            seen |= o_ready;
        end
        chk("midrst_no_rdy", 64'(seen), 64'd0);
        run("u77_4", 1'b0, 32'd77, 32'd4, 64'h00000001_00000013);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/div.md
# div

Multi-cycle 32-bit integer divider for the OpenMIPS execute stage, serving DIV and DIVU. The EX stage starts a division, stalls the pipeline until `o_ready`, then writes `o_result` into HI/LO. It uses a radix-2 restoring algorithm, one quotient bit per clock. It sits inside `openmips` and therefore runs under the SOPC top-level simulation.

## Interface
Parameters:
- none. Operand width is fixed at 32, result width at 64.

Ports:
- `i_clk`  input  1  single clock, rising-edge.
- `i_rst_n`  input  1  reset, synchronous, active-low.
- `i_signed_div`  input  1  1 = DIV (two's complement), 0 = DIVU.
- `i_opdata1`  input  32  dividend.
- `i_opdata2`  input  32  divisor.
- `i_start`  input  1  request. Held high by EX until `o_ready` is seen.
- `i_annul`  input  1  cancel (pipeline flush). Has priority over `i_start`.
- `o_result`  output  64  {remainder[63:32], quotient[31:0]}. Valid only while `o_ready` = 1, otherwise 0.
- `o_ready`  output  1  result valid.

## Operation
- State machine has four states: FREE, BYZERO, ON, END.
- Reset (edge with `i_rst_n` = 0): state FREE, `o_ready` = 0, `o_result` = 0, counter = 0. Reset overrides everything, including mid-division.
- FREE:
  - If `i_start` = 1 and `i_annul` = 0, latch `i_signed_div` and both operands.
  - If the divisor is 0, go to BYZERO. Otherwise go to ON with counter = 0.
  - In signed mode, negative operands are replaced by their two's-complement magnitude at latch time. Operand sign bits are kept for the final fix-up.
  - Working register is 65 bits, loaded as {32'b0, |dividend|, 1'b0}.
- BYZERO: next edge goes to END with result 0.
- ON:
  - If `i_annul` = 1, go to FREE. No result is produced and `o_ready` stays 0.
  - Else, if counter < 32, perform one step:
    - d = work[63:32] − {1'b0, divisor}, computed at 33 bits.
    - If d is negative: work = work << 1.
    - Else: work = {d[31:0], work[31:0], 1'b1} (shift in a quotient bit of 1).
    - Counter increments.
  - Else (counter = 32), go to END.
    - quotient = work[31:0], remainder = work[64:33].
    - Signed fix-up: negate the quotient if the operand signs differ. Negate the remainder if the dividend was negative; the remainder takes the dividend's sign.
    - Register `o_result`, set `o_ready` = 1.
- END:
  - Hold `o_result` and `o_ready` while `i_start` = 1.
  - When `i_start` = 0, go to FREE and clear `o_ready` and `o_result`.
  - `i_annul` in END also returns to FREE and clears outputs.
- Operand inputs are don't-care after the latch edge.
- Arithmetic wraps modulo 2^32. In signed mode, 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000, remainder 0.

## Timing
- Latency for a non-zero divisor:
  - E0 is the edge that samples `i_start` in FREE.
  - Edges E1–E32 perform the 32 steps.
  - E33 enters END. `o_ready` = 1 in the cycle after E33, which is 33 edges after acceptance.
- Latency for a zero divisor: E0 → BYZERO, E1 → END. `o_ready` = 1 after E1.
- `o_result` and `o_ready` are registered, with no combinational path from the inputs.
- Back-to-back operation:
  - Minimum one FREE cycle between operations, because `i_start` must drop to leave END.
  - A new start is accepted on the first edge in FREE.
- `i_annul` and `i_start` high on the same edge in FREE: the request is ignored and the state stays FREE.

## Test plan
- Unsigned 100 / 7:
  - Start at E0.
  - `o_ready` = 0 through E32.
  - After E33, `o_ready` = 1 and `o_result` = 0x00000002_0000000E.
  - Drop `i_start`; next edge gives `o_ready` = 0 and `o_result` = 0.
- Signed cases:
  - −7 / 2 → 0xFFFFFFFF_FFFFFFFD.
  - 7 / −2 → 0x00000001_FFFFFFFD.
  - 0x80000000 / 0xFFFFFFFF → 0x00000000_80000000.
- Unsigned 0xFFFFFFFF / 1 → 0x00000000_FFFFFFFF.
- Same operands in signed mode → 0x00000000_FFFFFFFF.
- Divide by zero, any dividend: `o_ready` = 1 after E1 with `o_result` = 0.
- Annul at E10 of an active division:
  - State returns to FREE and `o_ready` never rises.
  - A following 9 / 3 gives 0x00000000_00000003 after 33 edges.
- Reset: drive `i_rst_n` = 0 for one edge at E20.
  - Outputs are 0 and the state is FREE.
  - A new start after reset completes normally.
- Operand change after E0: the result reflects the latched values.
